// File: rtl/cpu_trace_buffer_pkg.sv
// cpu_trace_pkg: shared definitions for the CPU commit-trace recorder.
//
// Contents:
//   - record field widths and LSB offsets
//   - REC_W, the total record width
//   - HALT_OP, the opcode that ends a run
//   - trace_state_t, the recorder FSM states (RUN, DRAIN, DONE)
//
// Build option:
//   CPU_TRACE_MEMWRITE_EN, when defined, appends {DataMenRW, result} at the
//   LSB end of every record. REC_W is then 151 instead of 118.
package cpu_trace_pkg;

   localparam int CYC_W    = 16;
   localparam int PC_W     = 32;
   localparam int INSTR_W  = 32;
   localparam int REGWRE_W = 1;
   localparam int RD_W     = 5;
   localparam int WDATA_W  = 32;

`ifdef CPU_TRACE_MEMWRITE_EN
   localparam int MEMW_W   = 1;
   localparam int ADDR_W   = 32;
   localparam int EXT_W    = MEMW_W + ADDR_W;
`else
   localparam int EXT_W    = 0;
`endif

   // Fields are packed MSB to LSB:
   // cycle, PCout, instruction, RegWre, RFSelectorOut, writeData [, DataMenRW, result]
   localparam int WDATA_LSB  = EXT_W;
   localparam int RD_LSB     = WDATA_LSB + WDATA_W;
   localparam int REGWRE_LSB = RD_LSB + RD_W;
   localparam int INSTR_LSB  = REGWRE_LSB + REGWRE_W;
   localparam int PC_LSB     = INSTR_LSB + INSTR_W;
   localparam int CYC_LSB    = PC_LSB + PC_W;
   localparam int REC_W      = CYC_LSB + CYC_W;

   localparam logic [5:0] HALT_OP = 6'b111111;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } trace_state_t;

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// trace_fifo: synchronous FIFO used by the trace recorder.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_push, i_data write a word (accepted when not full, or when full and
//                  a pop happens in the same cycle)
//   i_pop          remove the head word (ignored when empty)
//   o_data         head word, read from the storage registers
//   o_full/o_empty occupancy flags
//   o_count        current occupancy, 0..DEPTH
//
// Pointers carry one extra wrap bit, so full and empty are told apart when
// the index bits are equal. The output comes straight from storage, so
// there is no path from i_data to o_data within a cycle.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   assign w_do_pop  = i_pop && !o_empty;
   // When full, the write slot is the head slot; it is free once the head
   // leaves at this same edge.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage is not reset: contents are meaningless once the pointers clear.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: commit-trace recorder placed after the single-cycle CPU.
//
// Each RUN cycle in which the CPU writes its PC, or executes a halt, is
// captured as one record into a FIFO. Records stream out on a valid/ready
// port. The run ends after CYCLE_LIMIT cycles or on a halt. The FIFO then
// drains and `done` rises.
//
// Ports:
//   CLK, Reset            clock and synchronous active-high reset
//   PCWre, PCout, instruction, RegWre, RFSelectorOut, writeData
//                         CPU architectural outputs sampled each cycle
//   DataMenRW, result     memory-write info (recorded only with the option)
//   trace_valid/ready     output handshake
//   trace_data            record (REC_W bits, see cpu_trace_pkg)
//   done                  run finished and FIFO empty
//   overflow, drop_cnt    sticky drop flag and saturating drop count
//   o_dbg_state           current FSM state
//
// Handshake: a record transfers on every rising edge where trace_valid and
// trace_ready are both 1. While trace_valid is 1 and trace_ready is 0,
// trace_data holds its value. trace_valid never depends on trace_ready.
//
// Build option: CPU_TRACE_MEMWRITE_EN appends {DataMenRW, result} to records.
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int CYCLE_LIMIT = 10
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               PCWre,
   input  logic [31:0]        PCout,
   input  logic [31:0]        instruction,
   input  logic               RegWre,
   input  logic [4:0]         RFSelectorOut,
   input  logic [31:0]        writeData,
   input  logic               DataMenRW,
   input  logic [31:0]        result,
   output logic               trace_valid,
   input  logic               trace_ready,
   output logic [REC_W-1:0]   trace_data,
   output logic               done,
   output logic               overflow,
   output logic [15:0]        drop_cnt,
   output trace_state_t       o_dbg_state
);

   localparam int          CNT_W      = $clog2(DEPTH) + 1;
   localparam logic [15:0] LAST_CYCLE = 16'(CYCLE_LIMIT - 1);

   trace_state_t     r_state;
   logic [15:0]      r_cycle;
   logic [15:0]      r_drop_cnt;
   logic             r_overflow;
   logic             r_done;

   logic [REC_W-1:0] w_rec;
   logic             w_halt;
   logic             w_capture;
   logic             w_pop;
   logic             w_drop;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;

   always_comb begin
      w_rec = '0;
      w_rec[CYC_LSB    +: CYC_W]    = r_cycle;
      w_rec[PC_LSB     +: PC_W]     = PCout;
      w_rec[INSTR_LSB  +: INSTR_W]  = instruction;
      w_rec[REGWRE_LSB +: REGWRE_W] = RegWre;
      w_rec[RD_LSB     +: RD_W]     = RFSelectorOut;
      w_rec[WDATA_LSB  +: WDATA_W]  = writeData;
`ifdef CPU_TRACE_MEMWRITE_EN
      w_rec[0 +: EXT_W]             = {DataMenRW, result};
`endif
   end

`ifndef CPU_TRACE_MEMWRITE_EN
   logic w_unused;
   assign w_unused = ^{DataMenRW, result};
`endif

   assign w_halt      = (instruction[31:26] == HALT_OP);
   // A halt is recorded even though the CPU holds its PC on that cycle.
   assign w_capture   = (r_state == RUN) && (PCWre || w_halt);
   assign trace_valid = !w_empty;
   assign w_pop       = trace_valid && trace_ready;
   assign w_drop      = w_capture && w_full && !w_pop;

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst   (Reset),
      .i_push  (w_capture),
      .i_pop   (w_pop),
      .i_data  (w_rec),
      .o_data  (trace_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state    <= RUN;
         r_cycle    <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         end
         case (r_state)
            RUN: begin
               r_cycle <= r_cycle + 16'd1;
               if (w_halt || (r_cycle == LAST_CYCLE)) r_state <= DRAIN;
            end
            DRAIN: begin
               // Nothing is pushed in DRAIN, so popping the last entry
               // leaves the FIFO empty after this edge.
               if (w_empty || (w_pop && (w_count == CNT_W'(1)))) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE:    r_state <= DONE;
            default: r_state <= RUN;
         endcase
      end
   end

   assign done        = r_done;
   assign overflow    = r_overflow;
   assign drop_cnt    = r_drop_cnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer with a queue-based reference model.
module tb_cpu_trace_buffer;
   import cpu_trace_pkg::*;

   localparam int DEPTH = 8;
   localparam int LIMIT = 10;

   // ---------------- clock / DUT ----------------
   logic               CLK = 1'b0;
   logic               Reset;
   logic               PCWre;
   logic [31:0]        PCout;
   logic [31:0]        instruction;
   logic               RegWre;
   logic [4:0]         RFSelectorOut;
   logic [31:0]        writeData;
   logic               DataMenRW;
   logic [31:0]        result;
   logic               trace_valid;
   logic               trace_ready;
   logic [REC_W-1:0]   trace_data;
   logic               done;
   logic               overflow;
   logic [15:0]        drop_cnt;
   trace_state_t       dbg_state;

   always #5 CLK = ~CLK;

   cpu_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .PCWre         (PCWre),
      .PCout         (PCout),
      .instruction   (instruction),
      .RegWre        (RegWre),
      .RFSelectorOut (RFSelectorOut),
      .writeData     (writeData),
      .DataMenRW     (DataMenRW),
      .result        (result),
      .trace_valid   (trace_valid),
      .trace_ready   (trace_ready),
      .trace_data    (trace_data),
      .done          (done),
      .overflow      (overflow),
      .drop_cnt      (drop_cnt),
      .o_dbg_state   (dbg_state)
   );

   // ---------------- model / scoreboard state ----------------
   logic [REC_W-1:0] exp_q[$];   // model FIFO contents, oldest first
   logic [REC_W-1:0] got_q[$];   // records actually handed out by the DUT
   int  m_phase;                 // 0 capturing, 1 draining, 2 finished
   int  m_cycle;
   int  m_drops;
   bit  m_ovf;
   int  n_checks = 0;
   int  n_fail   = 0;

   function automatic logic [REC_W-1:0] mk_rec(logic [15:0] cyc, logic [31:0] pc,
                                               logic [31:0] ins, logic rw, logic [4:0] rd,
                                               logic [31:0] wd, logic mw, logic [31:0] res);
`ifdef CPU_TRACE_MEMWRITE_EN
      return {cyc, pc, ins, rw, rd, wd, mw, res};
`else
      logic unused_m;
      unused_m = ^{mw, res};
      return {cyc, pc, ins, rw, rd, wd};
`endif
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] op;
      op = 6'($urandom_range(0, 62));
      return {op, 26'($urandom)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(bit pcwre, bit rdy, logic [31:0] pc, logic [31:0] ins);
      PCWre         = pcwre;
      trace_ready   = rdy;
      PCout         = pc;
      instruction   = ins;
      RegWre        = 1'($urandom);
      RFSelectorOut = 5'($urandom);
      writeData     = $urandom;
      DataMenRW     = 1'($urandom);
      result        = $urandom;
   endtask

   // One clock: scoreboard the handshake, advance the model, then compare
   // the DUT's registered outputs 1 time unit after the edge.
   task automatic tick();
      logic [REC_W-1:0] rec;
      bit pop, cap, halt, last;
      rec = '0;
      if (trace_valid === 1'b1 && trace_ready === 1'b1) begin
         got_q.push_back(trace_data);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %h, required no transfer", trace_data);
         end else if (trace_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL sb_data: got %h, required %h", trace_data, exp_q[0]);
         end
      end
      if (Reset) begin
         exp_q.delete();
         m_phase = 0; m_cycle = 0; m_drops = 0; m_ovf = 0;
      end else begin
         pop  = trace_ready && (exp_q.size() > 0);
         halt = (instruction[31:26] == 6'b111111);
         cap  = 0;
         last = 0;
         if (m_phase == 0) begin
            cap  = PCWre || halt;
            rec  = mk_rec(16'(m_cycle), PCout, instruction, RegWre, RFSelectorOut,
                          writeData, DataMenRW, result);
            last = halt || (m_cycle == LIMIT - 1);
            m_cycle++;
         end
         if (pop) void'(exp_q.pop_front());
         if (cap) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            else begin
               if (m_drops < 65535) m_drops++;
               m_ovf = 1;
            end
         end
         if (m_phase == 0 && last) m_phase = 1;
         else if (m_phase == 1 && exp_q.size() == 0) m_phase = 2;
      end
      @(posedge CLK);
      #1;
      n_checks += 4;
      if (trace_valid !== (exp_q.size() != 0)) begin
         n_fail++;
         $display("FAIL valid: got %b, required %b", trace_valid, exp_q.size() != 0);
      end
      if (done !== (m_phase == 2)) begin
         n_fail++;
         $display("FAIL done: got %b, required %b", done, m_phase == 2);
      end
      if (overflow !== m_ovf) begin
         n_fail++;
         $display("FAIL overflow: got %b, required %b", overflow, m_ovf);
      end
      if (drop_cnt !== 16'(m_drops)) begin
         n_fail++;
         $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, m_drops);
      end
   endtask

   task automatic do_reset(int n);
      Reset = 1'b1;
      drive(0, 0, 32'h0, 32'h0);
      repeat (n) tick();
      Reset = 1'b0;
      got_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset(2);
      n_checks += 4;
      if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", trace_valid); end
      if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
      if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
      if (drop_cnt !== 16'd0)   begin n_fail++; $display("FAIL reset_drop: got %0d, required 0", drop_cnt); end
   endtask

   task automatic test_basic();
      int n;
      for (int i = 0; i < LIMIT; i++) begin
         drive(1, 1, 32'(4 * i), rand_instr());
         tick();
      end
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         drive(1, 1, 32'h0, rand_instr());
         tick();
         n++;
      end
      n_checks += 3;
      if (done !== 1'b1)      begin n_fail++; $display("FAIL basic_done: got %b, required 1", done); end
      if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_drop: got %0d, required 0", drop_cnt); end
      if (got_q.size() != LIMIT) begin
         n_fail++; $display("FAIL basic_count: got %0d, required %0d", got_q.size(), LIMIT);
      end else begin
         for (int k = 0; k < LIMIT; k++) begin
            n_checks += 2;
            if (got_q[k][REC_W-1 -: 16] !== 16'(k)) begin
               n_fail++; $display("FAIL basic_cycle[%0d]: got %0d, required %0d", k, got_q[k][REC_W-1 -: 16], k);
            end
            if (got_q[k][REC_W-17 -: 32] !== 32'(4 * k)) begin
               n_fail++; $display("FAIL basic_pc[%0d]: got %h, required %h", k, got_q[k][REC_W-17 -: 32], 4 * k);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      do_reset(1);
      for (int i = 0; i < 12; i++) begin
         drive(1, 0, 32'(4 * i), rand_instr());
         tick();
      end
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         drive(1, 1, 32'h0, rand_instr());
         tick();
         n++;
      end
      n_checks += 4;
      if (done !== 1'b1)      begin n_fail++; $display("FAIL bp_done: got %b, required 1", done); end
      if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_drop: got %0d, required 2", drop_cnt); end
      if (overflow !== 1'b1)  begin n_fail++; $display("FAIL bp_ovf: got %b, required 1", overflow); end
      if (got_q.size() != 8) begin
         n_fail++; $display("FAIL bp_count: got %0d, required 8", got_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got_q[k][REC_W-1 -: 16] !== 16'(k)) begin
               n_fail++; $display("FAIL bp_cycle[%0d]: got %0d, required %0d", k, got_q[k][REC_W-1 -: 16], k);
            end
         end
      end
   endtask

   task automatic test_full_pop();
      int n;
      do_reset(1);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 32'(4 * i), rand_instr());
         tick();
      end
      drive(1, 1, 32'h20, rand_instr());   // FIFO full, pop and capture together
      tick();
      n_checks++;
      if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL fullpop_drop: got %0d, required 0", drop_cnt); end
      drive(1, 0, 32'h24, rand_instr());   // still 8 entries, so this one is lost
      tick();
      n_checks++;
      if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL fullpop_occupancy: got drop %0d, required 1", drop_cnt); end
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         drive(1, 1, 32'h0, rand_instr());
         tick();
         n++;
      end
      n_checks += 2;
      if (done !== 1'b1) begin n_fail++; $display("FAIL fullpop_done: got %b, required 1", done); end
      if (got_q.size() != DEPTH + 1) begin
         n_fail++; $display("FAIL fullpop_count: got %0d, required %0d", got_q.size(), DEPTH + 1);
      end
   endtask

   task automatic test_halt();
      int n;
      do_reset(1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'(4 * i), rand_instr());
         tick();
      end
      drive(0, 1, 32'hC, 32'hFC00_0000);
      tick();
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         drive(1, 1, 32'h0, rand_instr());
         tick();
         n++;
      end
      n_checks += 2;
      if (done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %b, required 1", done); end
      if (got_q.size() != 4) begin
         n_fail++; $display("FAIL halt_count: got %0d, required 4", got_q.size());
      end else begin
         n_checks += 2;
         if (got_q[3][REC_W-49 -: 32] !== 32'hFC00_0000) begin
            n_fail++; $display("FAIL halt_instr: got %h, required fc000000", got_q[3][REC_W-49 -: 32]);
         end
         if (got_q[3][REC_W-1 -: 16] !== 16'd3) begin
            n_fail++; $display("FAIL halt_cycle: got %0d, required 3", got_q[3][REC_W-1 -: 16]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 32'(4 * i), rand_instr());
         tick();
      end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      n_checks++;
      if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", trace_valid); end
      got_q.delete();
      drive(1, 1, 32'h100, rand_instr());
      tick();
      tick();
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++; $display("FAIL rstmid_first: got no record, required cycle 0");
      end else if (got_q[0][REC_W-1 -: 16] !== 16'd0) begin
         n_fail++; $display("FAIL rstmid_first: got cycle %0d, required 0", got_q[0][REC_W-1 -: 16]);
      end
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 4; r++) begin
         do_reset(1);
         for (int i = 0; i < 20; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), $urandom,
                  ($urandom_range(0, 15) == 0) ? {6'b111111, 26'($urandom)} : rand_instr());
            tick();
         end
         n = 0;
         while (done !== 1'b1 && n < 40) begin
            drive(1, 1, 32'h0, rand_instr());
            tick();
            n++;
         end
         n_checks++;
         if (done !== 1'b1) begin n_fail++; $display("FAIL rand_done[%0d]: got %b, required 1", r, done); end
      end
   endtask

`ifdef CPU_TRACE_MEMWRITE_EN
   task automatic test_memwrite();
      do_reset(1);
      drive(1, 0, 32'h0, rand_instr());
      DataMenRW = 1'b1;
      result    = 32'h10;
      tick();
      n_checks++;
      if (trace_data[32:0] !== {1'b1, 32'h10}) begin
         n_fail++; $display("FAIL memwrite: got %h, required 100000010", trace_data[32:0]);
      end
   endtask
`endif

   initial begin
      Reset = 1'b1;
      drive(0, 0, 32'h0, 32'h0);
      m_phase = 0; m_cycle = 0; m_drops = 0; m_ovf = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_full_pop();
      test_halt();
      test_reset_mid();
      test_random();
`ifdef CPU_TRACE_MEMWRITE_EN
      test_memwrite();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Commit-trace recorder sitting directly downstream of the single-cycle `CPU`. It samples the CPU's per-cycle architectural outputs (PC, instruction, register write-back) into a FIFO and streams the records out over a valid/ready port. It ends the run after a configured cycle budget or when a halt instruction executes, then drains and raises `done`. This replaces ad-hoc cycle counting in benches and gives a synthesizable trace tap.

## Interface
- `DEPTH`, 8: FIFO entries; power of 2, at least 2.
- `CYCLE_LIMIT`, 10: number of RUN cycles before capture stops; range 1..65535.
- `CLK` in, 1: clock; all logic is on the rising edge.
- `Reset` in, 1: synchronous, active-high.
- `PCWre` in, 1: CPU PC-write enable; 0 on halt.
- `PCout` in, 32: PC of the executing instruction.
- `instruction` in, 32: current instruction word.
- `RegWre` in, 1: register-file write enable.
- `RFSelectorOut` in, 5: destination register.
- `writeData` in, 32: register write-back data.
- `DataMenRW` in, 1: data-memory write (used only with the macro).
- `result` in, 32: ALU result / memory address (used only with the macro).
- `trace_valid` out, 1: a record is presented.
- `trace_ready` in, 1: consumer accepts the record.
- `trace_data` out, `REC_W`: the record; `REC_W` is 118, or 151 with the macro.
- `done` out, 1: run finished and FIFO empty.
- `overflow` out, 1: sticky; at least one record dropped.
- `drop_cnt` out, 16: dropped records, saturating at 16'hFFFF.

## Operation
- Record layout, MSB to LSB: `cycle`[15:0], `PCout`, `instruction`, `RegWre`, `RFSelectorOut`, `writeData`.
- States:
  - RUN (the reset state): capture records.
  - DRAIN: no capture; stay until the FIFO is empty.
  - DONE: terminal state; leaves only on `Reset`.
- Cycle counter (16 bits):
  - Cleared by reset.
  - Increments on every RUN cycle, independent of `PCWre`.
  - A record's `cycle` field holds the counter value at the capture edge.
- Halt condition: `instruction[31:26]` == 6'b111111.
- Capture in RUN when `PCWre` is 1 or the halt condition is true.
- RUN to DRAIN at the edge where either:
  - the halt is captured, or
  - the counter equals `CYCLE_LIMIT`-1.
- `CYCLE_LIMIT` cycles with `PCWre`=1 therefore produce exactly `CYCLE_LIMIT` records, with cycle 0 through `CYCLE_LIMIT`-1.
- DRAIN to DONE when the FIFO is empty. This can be the same edge as the last pop, so `done` rises the cycle after the last handshake.
- FIFO full on capture:
  - If a pop happens the same cycle, the push is accepted and the occupancy is unchanged.
  - Otherwise the record is dropped, `drop_cnt` increments and `overflow` is set.
- Output handshake:
  - A transfer occurs when `trace_valid` and `trace_ready` are both 1.
  - `trace_data` is stable while `trace_valid` is 1 and `trace_ready` is 0.
- Reset in any state:
  - FIFO contents are discarded.
  - Counters and `overflow` are cleared.
  - The state returns to RUN.

## Timing
- Reset values: `trace_valid`=0, `done`=0, `overflow`=0, `drop_cnt`=0. `trace_data` is don't-care while `trace_valid` is 0.
- Latency: a record captured at edge N is visible on `trace_data` after edge N, so `trace_valid`=1 in cycle N+1.
- There is no combinational bypass from the inputs to `trace_data`.
- Throughput: one capture and one pop per cycle.
- The first capture is at the first rising edge with `Reset`=0.
- Pop on empty: impossible, because `trace_valid`=0 when the FIFO is empty.
- Pointer wrap is modulo `DEPTH`; full and empty are distinguished with an extra pointer bit.

## Configuration
- `CPU_TRACE_MEMWRITE_EN`:
  - Defined: each record appends `DataMenRW` and `result` at the LSB end, giving `REC_W`=151.
  - Undefined: these ports are ignored and `REC_W`=118.

## Structure
- Package `cpu_trace_pkg` holds:
  - the record field widths and offsets;
  - `REC_W`, derived from the macro;
  - `HALT_OP` = 6'b111111;
  - the state enum (RUN, DRAIN, DONE).
- Sub-module `trace_fifo`:
  - Parameters: `WIDTH`, `DEPTH`.
  - Synchronous FIFO with registered output.
  - Exposes push, pop, full, empty.
- The top level holds the FSM, the counters and the drop logic.

## Test plan
- Basic run:
  - Stimulus: reset for 2 cycles, then `PCWre`=1, `trace_ready`=1, PC stepping 0,4,…,36.
  - Response: 10 records with cycle 0..9 and PC 0..0x24, then `done`=1 with `drop_cnt`=0.
- Backpressure:
  - Stimulus: `trace_ready`=0 for 12 cycles, then 1.
  - Response: `drop_cnt`=2, `overflow`=1, 8 records delivered with cycle 0..7, then `done`.
- Halt:
  - Stimulus: `instruction`=32'hFC000000 with `PCWre`=0 at cycle 3.
  - Response: 4 records, the last with instr FC000000; no further captures; `done`.
- Full with simultaneous pop:
  - Stimulus: FIFO full, `trace_ready`=1 on a capture cycle.
  - Response: occupancy stays 8 and `drop_cnt` is unchanged.
- Reset mid-run:
  - Stimulus: 5 records queued, `Reset` pulsed for 1 cycle.
  - Response: `trace_valid`=0 after the edge; the next record has cycle 0.
- Memory-write field, macro defined:
  - Stimulus: `DataMenRW`=1, `result`=32'h10.
  - Response: record bits [32:0] = {1, 32'h10}.
